lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWR, default 750000: power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 Parameter T_SU, default 2: RS/DATA setup cycles before EN rises.
REQ-003 Parameter T_EN, default 12: EN high-pulse width in cycles.
REQ-004 Parameter T_HOLD, default 2: RS/DATA hold cycles after EN falls.
REQ-005 Parameter T_EXEC, default 2500: post-command execution wait, normal commands and data.
REQ-006 Parameter T_CLR, default 82000: post-command wait for clear/home commands.
REQ-007 clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 i_wr_valid  in  1  host write strobe, driven from the LSU decode of the LCD register window 0x7030-0x703F.
REQ-010 i_wr_data  in  9  bit 8 = RS (1 data, 0 command); bits 7:0 = byte.
REQ-011 o_wr_ready  out  1  FIFO not full; write accepted when valid and ready.
REQ-012 o_busy  out  1  controller active or FIFO non-empty.
REQ-013 o_overflow  out  1  sticky; write offered while not ready.
REQ-014 o_lcd_on  out  1  panel power/backlight enable.
REQ-015 o_lcd_en, o_lcd_rs, o_lcd_rw  out  1 each  HD44780 strobe, register select, read/write.
REQ-016 o_lcd_data  out  8  HD44780 data bus.

Function
REQ-017 4-entry 9-bit FIFO; push when i_wr_valid && o_wr_ready; o_wr_ready = !full from registered count; push while full is never accepted, even if a pop occurs in the same cycle.
REQ-018 i_wr_valid && !o_wr_ready sets o_overflow; it stays set until rst.
REQ-019 FSM states: INIT_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-020 INIT_WAIT: count T_PWR cycles with EN=0; at the end set o_lcd_on=1, load init index 0, go to SETUP.
REQ-021 Init sequence: commands 0x38, 0x0C, 0x01, 0x06 with RS=0, in order, each through SETUP→PULSE→HOLD→EXEC; after the EXEC of 0x06, go to IDLE.
REQ-022 FIFO pushes are accepted during INIT_WAIT and the init sequence; FIFO is not popped until IDLE.
REQ-023 IDLE with FIFO non-empty: pop the head on that edge, latch it into o_lcd_rs/o_lcd_data, go to SETUP.
REQ-024 SETUP: T_SU cycles with EN=0. PULSE: T_EN cycles with EN=1. HOLD: T_HOLD cycles with EN=0, RS/DATA unchanged.
REQ-025 Latency: entry pushed on edge k into an empty FIFO in IDLE pops on edge k+1; EN rises on edge k+1+T_SU and falls on edge k+1+T_SU+T_EN.
REQ-026 EXEC waits T_CLR if RS=0 and byte[7:1]==7'b0000001 or byte==0x01; otherwise it waits T_EXEC; then IDLE.
REQ-027 RS/DATA hold their last value outside SETUP..HOLD; o_lcd_rw is constant 0 (write-only, no busy-flag polling).
REQ-028 o_busy = (state != IDLE) || FIFO non-empty.
REQ-029 One cycle counter of width clog2 of the largest parameter is reloaded on every state entry; a zero-length phase parameter is treated as 1.

Reset
REQ-030 rst has priority over all events: FSM→INIT_WAIT, FIFO emptied, counter and init index cleared.
REQ-031 Reset values: o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_on, o_overflow = 0; o_lcd_data = 0x00; o_busy = 1; o_wr_ready = 1.
REQ-032 rst mid-pulse drops EN on the next edge and restarts the full init sequence.

Structure
REQ-033 Package lcd_pkg holds: state enum, init command ROM constants, RS bit index, clear/home opcode constants.
REQ-034 FIFO is sub-module lcd_fifo (parameterised depth and width, synchronous reset); the FSM and timers live in lcd_ctrl.

Verification (params T_PWR=10, T_SU=1, T_EN=2, T_HOLD=1, T_EXEC=4, T_CLR=8)
REQ-035 Reset release, no writes -> four EN pulses with RS=0, data 0x38, 0x0C, 0x01, 0x06 in order; gap after 0x01 ≥ 8 cycles; o_lcd_on=1 from cycle 10; then o_busy=0.
REQ-036 After init, write 0x141 -> RS=1, data 0x41, EN high exactly 2 cycles starting 2 edges after the push; o_busy low 4 cycles after HOLD ends.
REQ-037 Five back-to-back writes during INIT_WAIT -> first four accepted, o_wr_ready=0 on the fifth, o_overflow=1; four data pulses follow init in push order.
REQ-038 Write 0x002 then 0x041 -> EXEC after 0x02 lasts 8 cycles; EXEC after 0x41 lasts 4 cycles.
REQ-039 Assert rst during PULSE of a data write -> EN=0 the next cycle, FIFO empty, o_overflow=0, init sequence replays from 0x38.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_t;

    localparam int WORD_W     = 9;
    localparam int RS_BIT     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int INIT_LEN   = 4;

    localparam logic [7:0] INIT_CMD_0 = 8'h38;
    localparam logic [7:0] INIT_CMD_1 = 8'h0C;
    localparam logic [7:0] INIT_CMD_2 = 8'h01;
    localparam logic [7:0] INIT_CMD_3 = 8'h06;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [6:0] CMD_HOME_HI = 7'b0000001;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_CMD_0;
            2'd1:    return INIT_CMD_1;
            2'd2:    return INIT_CMD_2;
            default: return INIT_CMD_3;
        endcase
    endfunction

    // Clear display and return home need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] byte_val);
        return !rs && ((byte_val == CMD_CLEAR) || (byte_val[7:1] == CMD_HOME_HI));
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO; a push while full is dropped even if a pop happens that cycle.
module lcd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-on wait, fixed init sequence, then FIFO-fed
// command/data writes with setup, enable pulse, hold and execution timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWR  = 750000,
    parameter int T_SU   = 2,
    parameter int T_EN   = 12,
    parameter int T_HOLD = 2,
    parameter int T_EXEC = 2500,
    parameter int T_CLR  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_valid,
    input  logic [8:0] i_wr_data,
    output logic       o_wr_ready,
    output logic       o_busy,
    output logic       o_overflow,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_of(max_of(max_of(T_PWR, T_SU), max_of(T_EN, T_HOLD)),
                                  max_of(T_EXEC, T_CLR));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Terminal count for a phase; a zero-length phase still lasts one cycle.
    function automatic logic [CNT_W-1:0] last_cnt(input int t);
        return (t <= 1) ? '0 : CNT_W'(t - 1);
    endfunction

    localparam logic [CNT_W-1:0] LAST_PWR  = last_cnt(T_PWR);
    localparam logic [CNT_W-1:0] LAST_SU   = last_cnt(T_SU);
    localparam logic [CNT_W-1:0] LAST_EN   = last_cnt(T_EN);
    localparam logic [CNT_W-1:0] LAST_HOLD = last_cnt(T_HOLD);
    localparam logic [CNT_W-1:0] LAST_EXEC = last_cnt(T_EXEC);
    localparam logic [CNT_W-1:0] LAST_CLR  = last_cnt(T_CLR);

    lcd_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        init_idx;
    logic              init_done;
    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CNT_W-1:0]  exec_last;

    assign pop        = (state == IDLE) && !fifo_empty;
    assign o_wr_ready = !fifo_full;
    assign o_busy     = (state != IDLE) || !fifo_empty;
    assign o_lcd_rw   = 1'b0;
    assign exec_last  = is_long_cmd(o_lcd_rs, o_lcd_data) ? LAST_CLR : LAST_EXEC;

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (i_wr_valid),
        .pop     (pop),
        .wr_data (i_wr_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT_WAIT;
            cnt        <= '0;
            init_idx   <= '0;
            init_done  <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            if (i_wr_valid && !o_wr_ready) o_overflow <= 1'b1;

            case (state)
                INIT_WAIT: begin
                    if (cnt == LAST_PWR) begin
                        o_lcd_on   <= 1'b1;
                        init_idx   <= 2'd0;
                        o_lcd_rs   <= 1'b0;
                        o_lcd_data <= init_cmd(2'd0);
                        cnt        <= '0;
                        state      <= SETUP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (!fifo_empty) begin
                        o_lcd_rs   <= head[RS_BIT];
                        o_lcd_data <= head[7:0];
                        cnt        <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == LAST_SU) begin
                        o_lcd_en <= 1'b1;
                        cnt      <= '0;
                        state    <= PULSE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt == LAST_EN) begin
                        o_lcd_en <= 1'b0;
                        cnt      <= '0;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == LAST_HOLD) begin
                        cnt   <= '0;
                        state <= EXEC;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    // During init, chain straight into the next ROM command.
                    if (cnt == exec_last) begin
                        cnt <= '0;
                        if (!init_done && (init_idx != 2'(INIT_LEN - 1))) begin
                            init_idx   <= init_idx + 2'd1;
                            o_lcd_rs   <= 1'b0;
                            o_lcd_data <= init_cmd(init_idx + 2'd1);
                            state      <= SETUP;
                        end else begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: a transaction-timeline reference model predicts every EN pulse,
// FIFO acceptance and the final idle edge; observed pulses are collected by a monitor.
module tb_lcd_ctrl;

    localparam int T_PWR  = 10;
    localparam int T_SU   = 1;
    localparam int T_EN   = 2;
    localparam int T_HOLD = 1;
    localparam int T_EXEC = 4;
    localparam int T_CLR  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_wr_valid = 1'b0;
    logic [8:0] i_wr_data = 9'h000;
    logic       o_wr_ready, o_busy, o_overflow, o_lcd_on;
    logic       o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    lcd_ctrl #(
        .T_PWR(T_PWR), .T_SU(T_SU), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
    ) dut (
        .clk(clk), .rst(rst), .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .o_busy(o_busy), .o_overflow(o_overflow),
        .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
        .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    int base = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Observed pulses, in edge numbers relative to reset release.
    int         mon_rise[$];
    int         mon_fall[$];
    logic       mon_rs[$];
    logic [7:0] mon_data[$];
    int         busy_fall = -1;
    logic       en_q = 1'b0;
    logic       busy_q = 1'b1;

    always @(negedge clk) begin
        if (o_lcd_en && !en_q) begin
            mon_rise.push_back(edge_n - base);
            mon_rs.push_back(o_lcd_rs);
            mon_data.push_back(o_lcd_data);
        end else if (o_lcd_en && en_q && mon_rs.size() > 0) begin
            n_checks++;
            if (o_lcd_rs !== mon_rs[$] || o_lcd_data !== mon_data[$]) begin
                n_errors++;
                $display("FAIL pulse_stable t=%0d: rs/data %b/%h, required %b/%h",
                         edge_n - base, o_lcd_rs, o_lcd_data, mon_rs[$], mon_data[$]);
            end
        end
        if (!o_lcd_en && en_q) mon_fall.push_back(edge_n - base);
        if (!o_busy && busy_q) busy_fall = edge_n - base;
        en_q   = o_lcd_en;
        busy_q = o_busy;
    end

    // Reference model: each write is a transaction start -> setup -> pulse -> hold -> exec.
    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int         exp_rise[$];
    int         exp_fall[$];
    logic       exp_rs[$];
    logic [7:0] exp_data[$];
    int         h_pop[$];
    int         m_end;
    logic       exp_ovf;

    task automatic model_txn(input int s, input logic [8:0] w);
        int  rise;
        int  fall;
        logic slow;
        rise = s + T_SU;
        fall = rise + T_EN;
        slow = (w[8] == 1'b0) && (w[7:0] >= 8'h01) && (w[7:0] <= 8'h03);
        exp_rise.push_back(rise);
        exp_fall.push_back(fall);
        exp_rs.push_back(w[8]);
        exp_data.push_back(w[7:0]);
        m_end = fall + T_HOLD + (slow ? T_CLR : T_EXEC);
    endtask

    task automatic model_reset();
        exp_rise.delete(); exp_fall.delete(); exp_rs.delete(); exp_data.delete();
        h_pop.delete();
        exp_ovf = 1'b0;
        m_end = T_PWR;
        for (int i = 0; i < 4; i++) model_txn(m_end, {1'b0, init_cmds[i]});
    endtask

    task automatic model_push(input logic [8:0] w, input int p);
        int s;
        s = ((m_end > p) ? m_end : p) + 1;
        h_pop.push_back(s);
        model_txn(s, w);
    endtask

    function automatic int occupancy(input int t);
        int n = 0;
        foreach (h_pop[j]) if (h_pop[j] > t) n++;
        return n;
    endfunction

    task automatic clear_monitor();
        mon_rise.delete(); mon_fall.delete(); mon_rs.delete(); mon_data.delete();
        busy_fall = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        clear_monitor();
        model_reset();
        rst = 1'b0;
        base = edge_n;
    endtask

    task automatic run_until(input int r);
        while (edge_n - base < r) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the next posedge.
    task automatic offer(input logic [8:0] w);
        int   t;
        logic pred;
        t = edge_n - base;
        pred = (occupancy(t) < 4);
        n_checks++;
        if (o_wr_ready !== pred) begin
            n_errors++;
            $display("FAIL wr_ready t=%0d: got %b, required %b", t, o_wr_ready, pred);
        end
        if (pred) model_push(w, t + 1);
        else exp_ovf = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_data  = w;
        @(negedge clk);
        i_wr_valid = 1'b0;
    endtask

    task automatic check_pulses(input string name);
        int n;
        n_checks++;
        if (mon_rise.size() != exp_rise.size() || mon_fall.size() != exp_fall.size()) begin
            n_errors++;
            $display("FAIL %s pulse_count: got %0d rises/%0d falls, required %0d",
                     name, mon_rise.size(), mon_fall.size(), exp_rise.size());
        end
        n = exp_rise.size();
        if (mon_rise.size() < n) n = mon_rise.size();
        if (mon_fall.size() < n) n = mon_fall.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (mon_rise[i] != exp_rise[i] || mon_fall[i] != exp_fall[i] ||
                mon_rs[i] !== exp_rs[i] || mon_data[i] !== exp_data[i]) begin
                n_errors++;
                $display("FAIL %s pulse%0d: got rise %0d fall %0d rs %b data %h, required rise %0d fall %0d rs %b data %h",
                         name, i, mon_rise[i], mon_fall[i], mon_rs[i], mon_data[i],
                         exp_rise[i], exp_fall[i], exp_rs[i], exp_data[i]);
            end
        end
        n_checks++;
        if (busy_fall != m_end || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy_idle: got busy fall %0d busy %b, required fall %0d busy 0",
                     name, busy_fall, o_busy, m_end);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_bit("rst_en", o_lcd_en, 1'b0);
        check_bit("rst_rs", o_lcd_rs, 1'b0);
        check_bit("rst_rw", o_lcd_rw, 1'b0);
        check_bit("rst_on", o_lcd_on, 1'b0);
        check_bit("rst_overflow", o_overflow, 1'b0);
        check_bit("rst_busy", o_busy, 1'b1);
        check_bit("rst_ready", o_wr_ready, 1'b1);
        check_int("rst_data", int'(o_lcd_data), 0);
    endtask

    task automatic test_init();
        do_reset();
        run_until(T_PWR - 1);
        check_bit("lcd_on_before", o_lcd_on, 1'b0);
        run_until(T_PWR);
        check_bit("lcd_on_at", o_lcd_on, 1'b1);
        run_until(m_end + 3);
        check_pulses("init");
        n_checks++;
        if (mon_rise.size() < 4 || mon_fall.size() < 4 || mon_rise[3] - mon_fall[2] < T_CLR) begin
            n_errors++;
            $display("FAIL init_clear_gap: got %0d pulses, gap too short or missing", mon_rise.size());
        end
    endtask

    task automatic test_single_write();
        int p;
        p = edge_n - base + 1;
        offer(9'h141);
        run_until(m_end + 3);
        check_pulses("single");
        check_int("single_rise_latency", mon_rise[$] - p, 2);
        check_int("single_en_width", mon_fall[$] - mon_rise[$], 2);
        check_int("single_exec", busy_fall - (mon_fall[$] + T_HOLD), 4);
        check_bit("single_rs_held", o_lcd_rs, 1'b1);
    endtask

    task automatic test_clear_exec();
        offer(9'h002);
        offer(9'h041);
        run_until(m_end + 3);
        check_pulses("clear_exec");
        check_int("exec_after_02", mon_rise[$] - mon_fall[mon_fall.size() - 2] - T_HOLD - 1 - T_SU, 8);
        check_int("exec_after_41", busy_fall - mon_fall[$] - T_HOLD, 4);
    endtask

    task automatic test_back_to_back();
        do_reset();
        offer(9'h101);
        offer(9'h102);
        offer(9'h103);
        offer(9'h104);
        offer(9'h105);
        check_bit("b2b_overflow", o_overflow, 1'b1);
        run_until(m_end + 3);
        check_pulses("back_to_back");
        check_bit("b2b_overflow_sticky", o_overflow, 1'b1);
    endtask

    task automatic test_reset_mid_pulse();
        int waited = 0;
        offer(9'h155);
        offer(9'h1AA);
        offer(9'h133);
        while (!o_lcd_en && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_bit("mid_pulse_reached", o_lcd_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_bit("mid_en_dropped", o_lcd_en, 1'b0);
        check_bit("mid_busy", o_busy, 1'b1);
        check_bit("mid_ready", o_wr_ready, 1'b1);
        check_bit("mid_overflow_cleared", o_overflow, 1'b0);
        @(negedge clk);
        clear_monitor();
        model_reset();
        rst = 1'b0;
        base = edge_n;
        run_until(m_end + 8);
        check_pulses("mid_reset_replay");
    endtask

    task automatic test_random();
        logic [8:0] w;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, (i < 8) ? 1 : 9)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) w = {1'b0, 8'($urandom_range(1, 3))};
            else w = {1'b1, 8'($urandom_range(0, 255))};
            offer(w);
        end
        run_until(m_end + 3);
        check_pulses("random");
        check_bit("random_overflow", o_overflow, exp_ovf);
    endtask

    initial begin
        test_reset();
        test_init();
        test_single_write();
        test_clear_exec();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
